// File: rtl/count_tick_gen_pkg.sv
// Shared types and constants for the count_tick_gen tick generator.
package count_tick_pkg;

  // Controller states: waiting for start, generating ticks, signalling completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_state_t;

  // Width of the shots input; the internal shot counter needs one more bit
  // because a programmed 0 stands for 16 ticks.
  localparam int SHOT_W          = 4;
  localparam int SHOT_CNT_W      = SHOT_W + 1;
  localparam int SHOT_ZERO_MEANS = 16;

  // Convert the programmed shot count into the value loaded into the counter.
  function automatic logic [SHOT_CNT_W-1:0] shot_load(input logic [SHOT_W-1:0] shots);
    if (shots == '0) return SHOT_CNT_W'(SHOT_ZERO_MEANS);
    else             return {1'b0, shots};
  endfunction

endpackage

// File: rtl/count_tick_gen_if.sv
// Control/status bundle between the tick generator and its controller.
// master drives the configuration and start/stop; slave is the generator.
interface count_tick_gen_if #(parameter int WIDTH = 8);
  import count_tick_pkg::*;

  logic [WIDTH-1:0]  div;
  logic [SHOT_W-1:0] shots;
  logic              oneshot;
  logic              start;
  logic              stop;
  logic              t;
  logic              busy;
  logic              done;

  modport master (output div, shots, oneshot, start, stop,
                  input  t, busy, done);
  modport slave  (input  div, shots, oneshot, start, stop,
                  output t, busy, done);
endinterface

// File: rtl/count_tick_gen_prescaler.sv
// Reloadable down-counter that paces the tick generator. zero flags the
// cycle on which a tick is due; the counter then reloads instead of wrapping.
module count_tick_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] reload_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load on start, then count down and reload from zero while enabled.
  // NOTE: sequential state uses <= so every register sees pre-edge values;
  // the synchronous reset lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= reload_val;
    end else if (en) begin
      if (count_q == '0) count_q <= reload_val;
      else               count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/count_tick_gen.sv
// Programmable tick generator feeding the t input of the 4-bit down counter.
// Continuous or one-shot burst mode; all outputs registered.
// Optional build macro COUNT_TICK_GEN_DIV_LATCH_EN: capture div at start
// and use that value for every reload instead of reading div live.
module count_tick_gen
  import count_tick_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  count_tick_gen_if.slave  bus
);

  tick_state_t           state_q, state_d;
  logic [SHOT_CNT_W-1:0] shot_q, shot_d;
  logic                  oneshot_q, oneshot_d;
  logic                  t_d, done_d, busy_d;
  logic                  pre_load, pre_en, pre_zero;
  logic [WIDTH-1:0]      reload_div;
  logic [WIDTH-1:0]      reload_val;

`ifdef COUNT_TICK_GEN_DIV_LATCH_EN
  logic [WIDTH-1:0] div_q;

  // Hold the divisor captured at start for the whole run.
  always_ff @(posedge clk) begin
    if (!rst)          div_q <= '0;
    else if (pre_load) div_q <= bus.div;
  end

  assign reload_div = div_q;
`else
  assign reload_div = bus.div;
`endif

  // The initial load at start always takes the current div.
  assign reload_val = pre_load ? bus.div : reload_div;

  count_tick_prescaler #(.WIDTH(WIDTH)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .load       (pre_load),
    .en         (pre_en),
    .reload_val (reload_val),
    .zero       (pre_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, prescaler control and next output values.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shot_d    = shot_q;
    oneshot_d = oneshot_q;
    t_d       = 1'b0;
    done_d    = 1'b0;
    pre_load  = 1'b0;
    pre_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d   = RUN;
          pre_load  = 1'b1;
          shot_d    = shot_load(bus.shots);
          oneshot_d = bus.oneshot;
        end
      end
      RUN: begin
        // stop beats a coincident tick; start is ignored here.
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          pre_en = 1'b1;
          if (pre_zero) begin
            t_d = 1'b1;
            if (oneshot_q) begin
              shot_d = shot_q - 1'b1;
              if (shot_q == SHOT_CNT_W'(1)) state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        // stop has no effect here; completion is always reported.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Shot counter, mode latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shot_q    <= '0;
      oneshot_q <= 1'b0;
      bus.t     <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      shot_q    <= shot_d;
      oneshot_q <= oneshot_d;
      bus.t     <= t_d;
      bus.busy  <= busy_d;
      bus.done  <= done_d;
    end
  end

endmodule

// File: tb/tb_count_tick_gen.sv
// Directed testbench for count_tick_gen. Edge E0 is the edge sampling start;
// outputs are observed 1 ns after each rising edge.
module tb_count_tick_gen;
  import count_tick_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0] cnt_model;  // downstream 4-bit down counter fed by t

  count_tick_gen_if #(.WIDTH(WIDTH)) bus();

  count_tick_gen #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge; the counter model decrements on each observed tick.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.t === 1'b1) cnt_model = cnt_model - 4'd1;
  endtask

  task automatic idle_inputs();
    bus.div     = '0;
    bus.shots   = '0;
    bus.oneshot = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    n_checks++; if (bus.t !== 1'b0)    $display("FAIL reset_t: got %b expected 0", bus.t);       else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int ticks;
    int cyc;
    bus.div = 8'd3; bus.oneshot = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    ticks = 0; cyc = 0;
    while (ticks < 2 && cyc < 40) begin
      step(); cyc++;
      if (bus.t === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 2) $display("FAIL midrst_ticks: got %0d ticks expected 2 (timeout)", ticks); else n_pass++;
    n_checks++; if (cyc != 8)   $display("FAIL midrst_cycles: got %0d expected 8", cyc);                  else n_pass++;
    rst = 1'b0;
    step();
    n_checks++; if (bus.t !== 1'b0)    $display("FAIL midrst_t: got %b expected 0", bus.t);       else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", bus.done); else n_pass++;
    rst = 1'b1;
    ticks = 0;
    repeat (20) begin
      step();
      if (bus.t === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 0)        $display("FAIL midrst_quiet: got %0d ticks expected 0", ticks); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_idle: got %b expected 0", bus.busy);      else n_pass++;
  endtask

  task automatic test_continuous();
    logic exp_t;
    int   ticks;
    bus.div = 8'd4; bus.oneshot = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      exp_t = (k % 5 == 0);
      n_checks++; if (bus.t !== exp_t) $display("FAIL cont_t_E%0d: got %b expected %b", k, bus.t, exp_t); else n_pass++;
    end
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL cont_busy: got %b expected 1", bus.busy); else n_pass++;
    // E20 would be a tick edge; stop must suppress it.
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_checks++; if (bus.t !== 1'b0)    $display("FAIL stop_tick_t: got %b expected 0", bus.t);       else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL stop_busy: got %b expected 0", bus.busy);      else n_pass++;
    ticks = 0;
    repeat (10) begin
      step();
      if (bus.t === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 0) $display("FAIL stop_quiet: got %0d ticks expected 0", ticks); else n_pass++;
  endtask

  task automatic test_collisions();
    logic exp_t;
    bus.div = 8'd1; bus.oneshot = 1'b0;
    bus.start = 1'b1; bus.stop = 1'b1;
    step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL startstop_busy: got %b expected 0", bus.busy); else n_pass++;
    step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL startstop_busy2: got %b expected 0", bus.busy); else n_pass++;
    n_checks++; if (bus.t !== 1'b0)    $display("FAIL startstop_t: got %b expected 0", bus.t);        else n_pass++;
    // start held high through the whole run must not disturb the period.
    bus.stop = 1'b0; bus.div = 8'd2;
    step();
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_t = (k % 3 == 0);
      n_checks++; if (bus.t !== exp_t) $display("FAIL start_in_run_E%0d: got %b expected %b", k, bus.t, exp_t); else n_pass++;
    end
    bus.start = 1'b0; bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL start_in_run_stop: got %b expected 0", bus.busy); else n_pass++;
    step();
  endtask

  task automatic test_oneshot();
    logic exp_t;
    logic exp_done;
    logic exp_busy;
    cnt_model = 4'b0000;
    bus.div = 8'd2; bus.shots = 4'd3; bus.oneshot = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_t    = (k % 3 == 0) && (k <= 9);
      exp_done = (k == 10);
      exp_busy = (k < 10);
      n_checks++; if (bus.t !== exp_t)       $display("FAIL burst_t_E%0d: got %b expected %b", k, bus.t, exp_t);          else n_pass++;
      n_checks++; if (bus.done !== exp_done) $display("FAIL burst_done_E%0d: got %b expected %b", k, bus.done, exp_done); else n_pass++;
      n_checks++; if (bus.busy !== exp_busy) $display("FAIL burst_busy_E%0d: got %b expected %b", k, bus.busy, exp_busy); else n_pass++;
    end
    n_checks++; if (cnt_model !== 4'b1101) $display("FAIL burst_counter: got %b expected 1101", cnt_model); else n_pass++;
    // Back-to-back: start on the edge after done, first tick div+2 after done.
    bus.shots = 4'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL restart_busy: got %b expected 1", bus.busy); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_t    = (k == 3);
      exp_done = (k == 4);
      n_checks++; if (bus.t !== exp_t)       $display("FAIL restart_t_E%0d: got %b expected %b", k, bus.t, exp_t);          else n_pass++;
      n_checks++; if (bus.done !== exp_done) $display("FAIL restart_done_E%0d: got %b expected %b", k, bus.done, exp_done); else n_pass++;
    end
  endtask

  task automatic test_shots0_div0();
    logic exp_t;
    logic exp_done;
    int   ticks;
    cnt_model = 4'b0000;
    ticks = 0;
    bus.div = 8'd0; bus.shots = 4'd0; bus.oneshot = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (bus.t === 1'b1) ticks++;
      exp_t    = (k <= 16);
      exp_done = (k == 17);
      n_checks++; if (bus.t !== exp_t)       $display("FAIL s0_t_E%0d: got %b expected %b", k, bus.t, exp_t);          else n_pass++;
      n_checks++; if (bus.done !== exp_done) $display("FAIL s0_done_E%0d: got %b expected %b", k, bus.done, exp_done); else n_pass++;
    end
    n_checks++; if (ticks != 16)           $display("FAIL s0_ticks: got %0d expected 16", ticks);          else n_pass++;
    n_checks++; if (cnt_model !== 4'b0000) $display("FAIL s0_counter: got %b expected 0000", cnt_model);   else n_pass++;
    n_checks++; if (bus.busy !== 1'b0)     $display("FAIL s0_busy: got %b expected 0", bus.busy);          else n_pass++;
  endtask

  task automatic test_div_change();
    logic exp_t;
    bus.div = 8'd2; bus.oneshot = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
`ifdef COUNT_TICK_GEN_DIV_LATCH_EN
      exp_t = (k % 3 == 0);
`else
      exp_t = (k == 3) || (k == 6) || (k == 12) || (k == 18);
`endif
      n_checks++; if (bus.t !== exp_t) $display("FAIL divchg_t_E%0d: got %b expected %b", k, bus.t, exp_t); else n_pass++;
      if (k == 4) bus.div = 8'd5;
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL divchg_stop: got %b expected 0", bus.busy); else n_pass++;
  endtask

  initial begin
    cnt_model = 4'b0000;
    test_reset();
    test_reset_mid_run();
    test_continuous();
    test_collisions();
    test_oneshot();
    test_shots0_div0();
    test_div_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
